l0_tile_sequencer: RTL and testbench

- Upstream control stage for the Conv1D computation step counters.
- Splits the weight vector into L0-sized tiles and, per tile, fetches weights and inputs from L1 into the L0 buffers.
- Drives Comp_Reset, Computing, L0_Data_Is_Ready and the three L0 status codes.
- Uses L0_Computation_Step_Counter to detect end of compute, then waits for the output buffer to be drained before starting the next tile.

---
 rtl/l0_tile_sequencer.sv | 153 +++++++++++++++
 tb/tb_l0_tile_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/l0_tile_sequencer.sv
// Tile sequencer ahead of the Conv1D step counters: loads each L0 weight/input
// tile from L1, runs compute, and waits for the output drain before the next tile.
module l0_tile_sequencer #(
  parameter int Data_Width                   = 8,
  parameter int Addr_Width                   = 6,
  parameter int Weight_Nums                  = 4,
  parameter int L0_Weight_Nums               = 2,
  parameter int L0_Input_Nums                = 8,
  parameter int L0_Output_Nums               = 8,
  parameter int Nums_Pipeline_Stages         = 4,
  parameter int L0_Computation_Steps_in_bits = 5,
  parameter int L0_Computation_Steps         = L0_Weight_Nums*L0_Output_Nums+Nums_Pipeline_Stages-1,
  parameter int Tile_Nums                    = Weight_Nums/L0_Weight_Nums
) (
  input  logic                                  clk,
  input  logic                                  Rst_n,
  input  logic                                  Start,
  input  logic                                  L1_Rd_Valid,
  input  logic [Data_Width-1:0]                 L1_Rd_Data,
  output logic                                  L1_Rd_Ready,
  output logic [Addr_Width-1:0]                 L1_Rd_Addr,
  output logic                                  L0_Wr_En,
  output logic                                  L0_Wr_Sel,
  output logic [3:0]                            L0_Wr_Addr,
  output logic [Data_Width-1:0]                 L0_Wr_Data,
  input  logic [L0_Computation_Steps_in_bits:0] L0_Computation_Step_Counter,
  input  logic                                  Out_Drained,
  output logic                                  Comp_Reset,
  output logic                                  Computing,
  output logic                                  L0_Data_Is_Ready,
  output logic [1:0]                            L0_Weight_Status,
  output logic [1:0]                            L0_Input_Status,
  output logic [1:0]                            L0_Output_Status,
  output logic [$clog2(Tile_Nums):0]            Tile_Index,
  output logic                                  Done
);
  localparam int MaxBeats = (L0_Weight_Nums > L0_Input_Nums) ? L0_Weight_Nums : L0_Input_Nums;
  localparam int BeatW    = (MaxBeats > 1) ? $clog2(MaxBeats) : 1;
  localparam int TileW    = $clog2(Tile_Nums) + 1;
  localparam int StepW    = L0_Computation_Steps_in_bits + 1;

  localparam logic [1:0] ST_EMPTY = 2'b00, ST_LOADING = 2'b01, ST_FULL = 2'b10, ST_CONSUMED = 2'b11;

  typedef enum logic [2:0] {IDLE, CLEAR, LOAD_W, LOAD_I, COMPUTE, DRAIN, FINISH} state_t;

  state_t             state_q, state_d;
  logic [BeatW-1:0]   beat_q, beat_d;
  logic [TileW-1:0]   tile_q, tile_d;
  int unsigned        addr_full;
  logic               last_w, last_i, last_tile, step_end;

  assign last_w    = (beat_q == BeatW'(L0_Weight_Nums-1));
  assign last_i    = (beat_q == BeatW'(L0_Input_Nums-1));
  assign last_tile = (tile_q == TileW'(Tile_Nums-1));
  assign step_end  = (L0_Computation_Step_Counter == StepW'(L0_Computation_Steps-1));

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      tile_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      tile_q  <= tile_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    beat_d           = beat_q;
    tile_d           = tile_q;
    addr_full        = 0;
    L1_Rd_Ready      = 1'b0;
    L1_Rd_Addr       = '0;
    L0_Wr_En         = 1'b0;
    L0_Wr_Sel        = 1'b0;
    L0_Wr_Addr       = '0;
    L0_Wr_Data       = '0;
    Comp_Reset       = 1'b0;
    Computing        = 1'b0;
    L0_Data_Is_Ready = 1'b0;
    L0_Weight_Status = ST_EMPTY;
    L0_Input_Status  = ST_EMPTY;
    L0_Output_Status = ST_EMPTY;
    Done             = 1'b0;
    case (state_q)
      IDLE: if (Start) state_d = CLEAR;
      CLEAR: begin
        Comp_Reset = 1'b1;
        Computing  = 1'b1;
        beat_d     = '0;
        tile_d     = '0;
        state_d    = LOAD_W;
      end
      LOAD_W, LOAD_I: begin
        Computing   = 1'b1;
        L1_Rd_Ready = 1'b1;
        // Input words sit after the whole weight vector in L1.
        addr_full   = 32'(tile_q) * L0_Weight_Nums + 32'(beat_q);
        if (state_q == LOAD_I) addr_full = addr_full + Weight_Nums;
        L1_Rd_Addr  = Addr_Width'(addr_full);
        L0_Wr_Sel   = (state_q == LOAD_I);
        L0_Wr_Addr  = 4'(beat_q);
        L0_Weight_Status = (state_q == LOAD_W) ? ST_LOADING : ST_FULL;
        L0_Input_Status  = (state_q == LOAD_I) ? ST_LOADING : ST_EMPTY;
        if (L1_Rd_Valid) begin
          L0_Wr_En   = 1'b1;
          L0_Wr_Data = L1_Rd_Data;
          if (state_q == LOAD_W && last_w) begin
            beat_d  = '0;
            state_d = LOAD_I;
          end else if (state_q == LOAD_I && last_i) begin
            beat_d  = '0;
            state_d = COMPUTE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      COMPUTE: begin
        Computing        = 1'b1;
        L0_Data_Is_Ready = 1'b1;
        L0_Weight_Status = ST_FULL;
        L0_Input_Status  = ST_FULL;
        if (step_end) state_d = DRAIN;
      end
      DRAIN: begin
        Computing        = 1'b1;
        L0_Weight_Status = ST_CONSUMED;
        L0_Input_Status  = ST_CONSUMED;
        L0_Output_Status = ST_FULL;
        // The step counter clears itself when L0_Data_Is_Ready drops, so no Comp_Reset here.
        if (Out_Drained) begin
          if (last_tile) begin
            state_d = FINISH;
          end else begin
            tile_d  = tile_q + 1'b1;
            state_d = LOAD_W;
          end
        end
      end
      FINISH: begin
        Done    = 1'b1;
        tile_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign Tile_Index = tile_q;
endmodule

// File: tb/tb_l0_tile_sequencer.sv
// Randomized bench for l0_tile_sequencer: an L1 memory model supplies beats, and a
// scoreboard of expected L0 writes (built from the tile/address rules) is checked by a monitor.
module tb_l0_tile_sequencer;
  localparam int DW = 8, AW = 6, WN = 4, L0W = 2, L0I = 8, TN = 2, LAST_STEP = 18;

  logic          clk, Rst_n, Start, L1_Rd_Valid, Out_Drained;
  logic [DW-1:0] L1_Rd_Data;
  logic          L1_Rd_Ready, L0_Wr_En, L0_Wr_Sel, Comp_Reset, Computing, L0_Data_Is_Ready, Done;
  logic [AW-1:0] L1_Rd_Addr;
  logic [3:0]    L0_Wr_Addr;
  logic [DW-1:0] L0_Wr_Data;
  logic [5:0]    step;
  logic [1:0]    L0_Weight_Status, L0_Input_Status, L0_Output_Status;
  logic [1:0]    Tile_Index;

  l0_tile_sequencer dut (
    .clk(clk), .Rst_n(Rst_n), .Start(Start), .L1_Rd_Valid(L1_Rd_Valid), .L1_Rd_Data(L1_Rd_Data),
    .L1_Rd_Ready(L1_Rd_Ready), .L1_Rd_Addr(L1_Rd_Addr), .L0_Wr_En(L0_Wr_En), .L0_Wr_Sel(L0_Wr_Sel),
    .L0_Wr_Addr(L0_Wr_Addr), .L0_Wr_Data(L0_Wr_Data), .L0_Computation_Step_Counter(step),
    .Out_Drained(Out_Drained), .Comp_Reset(Comp_Reset), .Computing(Computing),
    .L0_Data_Is_Ready(L0_Data_Is_Ready), .L0_Weight_Status(L0_Weight_Status),
    .L0_Input_Status(L0_Input_Status), .L0_Output_Status(L0_Output_Status),
    .Tile_Index(Tile_Index), .Done(Done));

  typedef struct { logic sel; int waddr; int raddr; } wr_t;
  wr_t           q[$];
  logic [DW-1:0] mem [64];
  logic [DW-1:0] junk;
  int            total = 0, bad = 0;
  int            nwr = 0, ncr = 0, ndone = 0, vmode = 0;

  assign L1_Rd_Data = L1_Rd_Valid ? mem[L1_Rd_Addr] : junk;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Expected L0 writes for one job, straight from the tile/address layout of L1.
  task automatic push_job();
    for (int t = 0; t < TN; t++) begin
      for (int b = 0; b < L0W; b++) q.push_back('{1'b0, b, t*L0W + b});
      for (int b = 0; b < L0I; b++) q.push_back('{1'b1, b, WN + t*L0W + b});
    end
  endtask

  // L1 valid pattern driver, moved away from both clock edges.
  initial begin
    L1_Rd_Valid = 1'b1;
    junk = '0;
    forever begin
      @(posedge clk); #2;
      junk = 8'($urandom);
      case (vmode)
        0: L1_Rd_Valid = 1'b1;
        1: L1_Rd_Valid = ~L1_Rd_Valid;
        default: L1_Rd_Valid = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops an expected write on every L0 write strobe.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (Rst_n) begin
        if (Comp_Reset) ncr++;
        if (Done) ndone++;
        if (L0_Wr_En) begin
          nwr++;
          if (q.size() == 0) begin
            total++; bad++;
            $display("FAIL wr_unexpected: got sel=%0d waddr=%0d raddr=%0d want no write",
                     L0_Wr_Sel, L0_Wr_Addr, L1_Rd_Addr);
          end else begin
            e = q.pop_front();
            chk("l0_write{sel,waddr,raddr,data,hs}",
                {L0_Wr_Sel, L0_Wr_Addr, L1_Rd_Addr, L0_Wr_Data, L1_Rd_Valid & L1_Rd_Ready},
                {e.sel, 4'(e.waddr), 6'(e.raddr), mem[6'(e.raddr)], 1'b1});
          end
        end
      end
    end
  end

  function automatic logic [63:0] all_out();
    return {L1_Rd_Ready, L1_Rd_Addr, L0_Wr_En, L0_Wr_Sel, L0_Wr_Addr, L0_Wr_Data, Comp_Reset,
            Computing, L0_Data_Is_Ready, L0_Weight_Status, L0_Input_Status, L0_Output_Status,
            Tile_Index, Done};
  endfunction

  task automatic run_job(input int mode, input bit chk_lat, input bit rst_mid);
    int cyc, wr0, cr0, dn0, n;
    vmode = mode;
    wr0 = nwr; cr0 = ncr; dn0 = ndone;
    push_job();
    @(negedge clk); Start = 1'b1;
    @(posedge clk); #1; Start = 1'b0;
    chk("clear{comp_reset,computing,tile}", {Comp_Reset, Computing, Tile_Index}, {1'b1, 1'b1, 2'd0});
    for (int t = 0; t < TN; t++) begin
      if (rst_mid && t == 1) begin
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (L0_Input_Status != 2'b01 && cyc < 400);
        chk("reach_tile1_load_i", {Tile_Index, L0_Input_Status}, {2'd1, 2'b01});
        repeat ($urandom_range(0, 4)) @(posedge clk);
        @(negedge clk); #2;
        Rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", all_out(), 64'd0);
        q.delete();
        repeat (2) @(negedge clk);
        Rst_n = 1'b1;
        @(posedge clk); #1;
        chk("after_reset_idle", all_out(), 64'd0);
        return;
      end
      cyc = 0;
      do begin @(posedge clk); #1; cyc++; end while (!L0_Data_Is_Ready && cyc < 400);
      chk("ready_rise", L0_Data_Is_Ready, 1);
      if (chk_lat && t == 0) chk("ready_latency", cyc, 11);
      chk("compute{w,i,o,tile}", {L0_Weight_Status, L0_Input_Status, L0_Output_Status, Tile_Index},
          {2'b10, 2'b10, 2'b00, 2'(t)});
      n = $urandom_range(0, 5);
      repeat (n) begin
        @(negedge clk);
        step = 6'($urandom_range(0, LAST_STEP-1));
        Out_Drained = 1'($urandom_range(0, 1));
        Start = 1'($urandom_range(0, 1));
      end
      @(negedge clk); step = 6'(LAST_STEP); Out_Drained = 1'b0; Start = 1'b0;
      @(posedge clk); #1;
      chk("drain{ready,w,i,o,computing}", {L0_Data_Is_Ready, L0_Weight_Status, L0_Input_Status,
          L0_Output_Status, Computing}, {1'b0, 2'b11, 2'b11, 2'b10, 1'b1});
      @(negedge clk); step = '0; Start = 1'b1;
      @(negedge clk); Start = 1'b1;
      @(negedge clk); Start = 1'b0; Out_Drained = 1'b1;
      @(posedge clk); #1; Out_Drained = 1'b0;
      if (t < TN-1)
        chk("next_tile{w,i,o,tile,computing,done}", {L0_Weight_Status, L0_Input_Status,
            L0_Output_Status, Tile_Index, Computing, Done}, {2'b01, 2'b00, 2'b00, 2'(t+1), 1'b1, 1'b0});
      else
        chk("finish{w,i,o,computing,done}", {L0_Weight_Status, L0_Input_Status, L0_Output_Status,
            Computing, Done}, {2'b00, 2'b00, 2'b00, 1'b0, 1'b1});
    end
    @(posedge clk); #1;
    chk("idle_after{done,computing,tile}", {Done, Computing, Tile_Index}, {1'b0, 1'b0, 2'd0});
    @(negedge clk);
    chk("job_writes", nwr - wr0, 20);
    chk("job_comp_reset_cycles", ncr - cr0, 1);
    chk("job_done_pulses", ndone - dn0, 1);
    chk("scoreboard_empty", q.size(), 0);
    Out_Drained = 1'b1;
    @(posedge clk); #1; Out_Drained = 1'b0;
    chk("idle_ignores_drained", {Computing, Done, L1_Rd_Ready, L0_Data_Is_Ready, L0_Output_Status}, 0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
    Rst_n = 1'b0; Start = 1'b0; step = '0; Out_Drained = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_out(), 64'd0);
    Start = 1'b1;
    @(posedge clk); #1;
    chk("start_during_reset", all_out(), 64'd0);
    @(negedge clk); Start = 1'b0; Rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_outputs", all_out(), 64'd0);
    run_job(0, 1'b1, 1'b0);
    run_job(1, 1'b0, 1'b0);
    run_job(2, 1'b0, 1'b0);
    run_job(2, 1'b0, 1'b1);
    run_job(0, 1'b1, 1'b0);
    run_job(2, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
